// File: rtl/fifo_rd_packer.sv
// Read-side packer for the async FIFO: pops DATA_WIDTH entries, packs PACK_RATIO of
// them into one wide word on a valid/ready stream, with flush of partial words.
module fifo_rd_packer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PACK_RATIO = 4,
  parameter int unsigned CNT_W      = 3,
  parameter int unsigned WCNT_W     = 16
) (
  input  logic                             rclk,
  input  logic                             rrst,
  input  logic                             rempty,
  input  logic [DATA_WIDTH-1:0]            rdata,
  output logic                             rinc,
  input  logic                             flush,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] out_data,
  output logic [CNT_W-1:0]                 out_count,
  output logic                             flush_done,
  output logic [WCNT_W-1:0]                words_out
);

  localparam int unsigned OW = DATA_WIDTH * PACK_RATIO;

  typedef enum logic [1:0] {ACC, FULL, FLUSH} state_e;

  state_e            state;
  logic [OW-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;
  logic              flush_pending_q, flush_pending_d;
  logic              out_valid_q, out_valid_d;
  logic [OW-1:0]     out_data_q, out_data_d;
  logic [CNT_W-1:0]  out_count_q, out_count_d;
  logic              flush_done_q, flush_done_d;
  logic [WCNT_W-1:0] words_q, words_d;
  logic              out_free, has_data, xfer, pop;

  // State is a decoded view of acc_cnt and flush_pending, not a separate register.
  always_comb begin
    if (flush_pending_q)                          state = FLUSH;
    else if (acc_cnt_q == CNT_W'(PACK_RATIO))     state = FULL;
    else                                          state = ACC;
  end

  always_comb begin
    out_free = !out_valid_q || out_ready;
    has_data = (acc_cnt_q != '0);
    xfer     = 1'b0;
    unique case (state)
      ACC:     xfer = 1'b0;
      FULL:    xfer = out_free;
      FLUSH:   xfer = out_free && has_data;
      default: xfer = 1'b0;
    endcase
    pop  = !rrst && !rempty && ((state == ACC) || (state == FULL && xfer));
    rinc = pop;
  end

  always_comb begin
    acc_d           = acc_q;
    acc_cnt_d       = acc_cnt_q;
    out_valid_d     = out_valid_q;
    out_data_d      = out_data_q;
    out_count_d     = out_count_q;
    words_d         = words_q;
    flush_done_d    = (state == FLUSH) && (xfer || !has_data);
    flush_pending_d = (state == FLUSH) ? !flush_done_d : flush;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      words_d     = words_q + 1'b1;
    end

    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = acc_q;
      out_count_d = acc_cnt_q;
      acc_d       = '0;
      acc_cnt_d   = '0;
    end

    // After an xfer acc_cnt_d is zero, so a same-cycle pop lands in lane 0.
    if (pop) begin
      for (int unsigned i = 0; i < PACK_RATIO; i++) begin
        if (CNT_W'(i) == acc_cnt_d) acc_d[i*DATA_WIDTH +: DATA_WIDTH] = rdata;
      end
      acc_cnt_d = acc_cnt_d + 1'b1;
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      acc_q           <= '0;
      acc_cnt_q       <= '0;
      flush_pending_q <= 1'b0;
      out_valid_q     <= 1'b0;
      out_data_q      <= '0;
      out_count_q     <= '0;
      flush_done_q    <= 1'b0;
      words_q         <= '0;
    end else begin
      acc_q           <= acc_d;
      acc_cnt_q       <= acc_cnt_d;
      flush_pending_q <= flush_pending_d;
      out_valid_q     <= out_valid_d;
      out_data_q      <= out_data_d;
      out_count_q     <= out_count_d;
      flush_done_q    <= flush_done_d;
      words_q         <= words_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_count  = out_count_q;
  assign flush_done = flush_done_q;
  assign words_out  = words_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: directed phases plus random traffic, each cycle checked
// against a queue-based behavioural model of the packer.
module tb_fifo_rd_packer;

  localparam int unsigned DW = 8;
  localparam int unsigned PR = 4;

  logic          rclk, rrst, rempty, rinc, flush, out_valid, out_ready, flush_done;
  logic [DW-1:0] rdata;
  logic [31:0]   out_data;
  logic [2:0]    out_count;
  logic [15:0]   words_out;

  fifo_rd_packer #(.DATA_WIDTH(DW), .PACK_RATIO(PR), .CNT_W(3), .WCNT_W(16)) dut (
    .rclk(rclk), .rrst(rrst), .rempty(rempty), .rdata(rdata), .rinc(rinc),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .flush_done(flush_done), .words_out(words_out)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  int unsigned npass = 0, ntotal = 0;
  logic [7:0]  fifo_q[$];
  logic        stall;

  // Behavioural model: accumulated entries as a queue, plus the held output word.
  logic [7:0]  macc[$];
  logic        mhv, mdone, mpend;
  logic [31:0] mhd;
  logic [2:0]  mhc;
  logic [15:0] mwords;
  logic [31:0] last_word;
  logic [2:0]  last_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    macc.delete();
    mhv = 0; mdone = 0; mpend = 0; mhd = '0; mhc = '0; mwords = '0;
  endtask

  task automatic drive_fifo();
    rempty = (fifo_q.size() == 0) || stall;
    rdata  = (fifo_q.size() != 0) ? fifo_q[0] : 8'hEE;
  endtask

  task automatic chk_outputs();
    chk("out_valid", out_valid, mhv);
    chk("out_count", out_count, mhc);
    chk("out_data", out_data, mhd);
    chk("flush_done", flush_done, mdone);
    chk("words_out", words_out, mwords);
  endtask

  // One clock: inputs already set by caller; check rinc, advance model, check outputs.
  task automatic step();
    logic        free, full, x, p, n_done, n_pend;
    logic [31:0] pk;
    int unsigned sz;
    drive_fifo();
    #1;
    sz   = macc.size();
    free = !mhv || out_ready;
    full = (sz == PR);
    x    = free && (full || (mpend && sz > 0));
    p    = !rrst && !rempty && !mpend && (!full || x);
    chk("rinc", rinc, p);
    n_done = mpend && (x || sz == 0);
    n_pend = mpend ? !(x || sz == 0) : flush;
    pk = '0;
    for (int i = 0; i < int'(sz); i++) pk[i*8 +: 8] = macc[i];
    @(posedge rclk);
    if (rrst) model_reset();
    else begin
      if (mhv && out_ready) begin
        mhv = 0; mwords++;
        last_word = mhd; last_cnt = mhc;
      end
      if (x) begin
        mhv = 1; mhd = pk; mhc = 3'(sz); macc.delete();
      end
      if (p) begin
        macc.push_back(rdata);
        void'(fifo_q.pop_front());
      end
      mdone = n_done; mpend = n_pend;
    end
    #1;
    chk_outputs();
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) step();
  endtask

  initial begin
    rrst = 1; flush = 0; out_ready = 1; stall = 0;
    last_word = '0; last_cnt = '0;
    model_reset();
    fifo_q.push_back(8'h5A);
    drive_fifo();
    #1;
    chk("reset_rinc", rinc, 1'b0);
    chk_outputs();
    run(2);
    fifo_q.delete();
    rrst = 0;

    // Single word 44332211
    fifo_q.push_back(8'h11); fifo_q.push_back(8'h22);
    fifo_q.push_back(8'h33); fifo_q.push_back(8'h44);
    run(8);
    chk("first_word", last_word, 32'h44332211);
    chk("first_cnt", last_cnt, 3'd4);
    chk("words_1", words_out, 16'd1);

    // Continuous stream of 12
    for (int unsigned i = 0; i < 12; i++) fifo_q.push_back(8'(8'h80 + i));
    run(16);
    chk("words_4", words_out, 16'd4);
    chk("stream_last", last_word, 32'h8B8A8988);

    // Backpressure with 8 entries
    out_ready = 0;
    for (int unsigned i = 0; i < 8; i++) fifo_q.push_back(8'(8'hC0 + i));
    run(14);
    chk("bp_fifo_left", fifo_q.size(), 0);
    chk("bp_held", out_data, 32'hC3C2C1C0);
    out_ready = 1;
    run(4);
    chk("bp_second", last_word, 32'hC7C6C5C4);

    // Partial flush
    fifo_q.push_back(8'hAA); fifo_q.push_back(8'hBB);
    run(3);
    fifo_q.push_back(8'hCC);
    flush = 1; stall = 1; step(); flush = 0; stall = 0;
    run(5);
    chk("flush_word", last_word, 32'h0000BBAA);
    chk("flush_cnt", last_cnt, 3'd2);
    run(3);

    // Flush with empty accumulator, and rempty held high
    flush = 1; step(); flush = 0;
    run(3);
    stall = 1;
    fifo_q.push_back(8'h01);
    run(5);
    stall = 0;
    run(8);
    flush = 1; step(); flush = 0;
    run(4);

    // Random traffic
    for (int unsigned c = 0; c < 600; c++) begin
      if (($urandom % 3) != 0 && fifo_q.size() < 16) fifo_q.push_back(8'($urandom));
      out_ready = ($urandom % 4) != 0;
      flush     = ($urandom % 12) == 0;
      stall     = ($urandom % 6) == 0;
      step();
    end
    flush = 0; stall = 0; out_ready = 1;
    run(30);

    // Reset mid-word with a held word
    fifo_q.delete();
    out_ready = 0;
    for (int unsigned i = 0; i < 7; i++) fifo_q.push_back(8'(8'h30 + i));
    run(10);
    chk("pre_rst_valid", out_valid, 1'b1);
    #3;
    rrst = 1;
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_words", words_out, 16'd0);
    chk("rst_rinc", rinc, 1'b0);
    model_reset();
    run(1);
    rrst = 0;
    fifo_q.delete();
    out_ready = 1;
    fifo_q.push_back(8'hD1); fifo_q.push_back(8'hD2);
    fifo_q.push_back(8'hD3); fifo_q.push_back(8'hD4);
    run(8);
    chk("post_rst_word", last_word, 32'hD4D3D2D1);
    chk("post_rst_cnt", last_cnt, 3'd4);
    chk("post_rst_words", words_out, 16'd1);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
- Read-side consumer of the async FIFO, in the rclk domain.
- Pops DATA_WIDTH-bit entries through the FIFO's rinc/rempty/rdata interface and packs PACK_RATIO consecutive entries into one wide word.
- Presents the wide word on a valid/ready stream to downstream logic.
- A flush request emits a partially filled word, so tail data never sits in the packer.

Parameters:
- DATA_WIDTH, 8, width of one FIFO entry (rdata).
- PACK_RATIO, 4, entries per output word (>=2).
- CNT_W, 3, width of out_count; must hold PACK_RATIO.
- WCNT_W, 16, width of the words_out status counter.

Ports:
- rclk  in  1  read-domain clock; all state on posedge.
- rrst  in  1  asynchronous, active-high reset.
- rempty  in  1  FIFO empty flag; rdata is valid whenever rempty=0 (first-word fall-through).
- rdata  in  DATA_WIDTH  FIFO head entry.
- rinc  out  1  pop strobe to FIFO; one entry consumed per rclk with rinc=1.
- flush  in  1  single-cycle request to emit the current partial word.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_WIDTH*PACK_RATIO  packed word; first popped entry in lane 0 (LSBs).
- out_count  out  CNT_W  number of valid lanes in out_data (1..PACK_RATIO).
- flush_done  out  1  one-cycle pulse when a flush request has been retired.
- words_out  out  WCNT_W  count of accepted output words; wraps modulo 2^WCNT_W.

Behaviour:
- Clock and reset: one clock, rclk. Reset rrst is asynchronous, active-high.

- Reset values:
  - Outputs: out_valid=0, out_data=0, out_count=0, flush_done=0, words_out=0.
  - Internal: acc=0, acc_cnt=0, flush_pending=0.
  - rinc is forced 0 combinationally while rrst=1.
  - Reset mid-word discards the partial accumulator and any held output word; entries already popped are lost (documented, not recovered).

- Internal state:
  - Accumulator acc, PACK_RATIO lanes.
  - acc_cnt, 0..PACK_RATIO.
  - flush_pending flag.
  - Output holding register feeding out_data/out_count/out_valid.

- Transfer condition: out_free = !out_valid || out_ready. xfer = out_free && (acc_cnt==PACK_RATIO || (flush_pending && acc_cnt>0)).
- Pop rule: rinc = !rrst && !rempty && !flush_pending && (acc_cnt<PACK_RATIO || xfer).
  - Never pop when rempty=1.
  - No pops while a flush is pending.

- On xfer:
  - Holding register <= acc; unused lanes are zero.
  - out_count <= acc_cnt; out_valid <= 1.
  - acc cleared; acc_cnt <= 0, or 1 if rinc is also high that cycle (popped entry lands in lane 0 of the fresh word).
  - flush_pending <= 0.
  - flush_done pulses the following cycle only if flush_pending was set.
- Pop without xfer: acc lane[acc_cnt] <= rdata; acc_cnt += 1.
- Handshake:
  - out_valid && out_ready retires the held word; words_out += 1.
  - out_valid stays 0 unless xfer refills the register in the same cycle (back-to-back allowed).
  - out_data and out_count stay stable while out_valid=1 and out_ready=0.

- Flush:
  - flush=1 sets flush_pending next cycle.
  - A pop in the same cycle as flush is included in the flushed word.
  - flush with acc_cnt==0 and no same-cycle pop: flush_pending clears next cycle, flush_done pulses, no word emitted.
  - flush while flush_pending=1 is absorbed.
- FSM view, derived from acc_cnt and flush_pending:
  - ACC: acc_cnt<PACK_RATIO, no flush. Goes to FULL on the pop that fills the last lane.
  - FULL: acc_cnt=PACK_RATIO, waiting for out_free. Goes to ACC on xfer.
  - FLUSH: flush_pending set. Goes to ACC on xfer or empty retire.
- Latency: the pop of the last lane is followed by out_valid=1 on the next edge when out_free.
- Throughput: one entry per cycle sustained with out_ready=1; no bubble between words.

Test Plan:
- Reset, then FIFO supplies 8'h11,22,33,44 with out_ready=1 -> out_valid one cycle after 4th pop, out_data=32'h44332211, out_count=4, words_out=1.
- Continuous stream of 12 entries, out_ready=1 -> rinc high 12 consecutive cycles, 3 words back-to-back, words_out=3.
- out_ready=0 with 8 entries available -> first word held stable, second accumulator fills, rinc drops after 8 pops. Raise out_ready -> both words emitted in order.
- Pop 8'hAA,BB then flush -> out_data=32'h0000BBAA, out_count=2, flush_done pulse, no pops while flush_pending.
- flush with empty accumulator -> no out_valid, flush_done pulses once. rempty=1 throughout -> rinc never asserted.
- Assert rrst after 3 pops with out_valid=1 -> out_valid=0, words_out=0, rinc=0 immediately. After release a fresh 4 pops yields out_count=4.
